// File: rtl/my_design.sv
// my_design: single-layer 3x3 CNN accelerator between four synchronous SRAMs.
//
// On dut_run (sampled only in IDLE) the block streams the 3x3 signed kernel
// (weights words 0..4) and the NxN signed 8-bit image (input words) into
// internal registers. It then evaluates the valid 3x3 convolution one output
// pixel per cycle, clamps each sum to 0..127 (ReLU + saturate), and writes the
// (N-2)x(N-2) result bytes to the output SRAM, packed two per word in
// ascending address order.
//
// Optional feature (macro MULTI_INPUT_EN): the input SRAM holds a chain of
// matrices, each preceded by a size word Nc (even, 4..64). The kernel is
// loaded once per run, results are appended to the output SRAM, and the run
// ends on a size word of 16'hFFFF. Without the macro the size is fixed at N
// and the image starts at input word 0.
//
// Ports:
//   clk, reset_b                  clock, asynchronous active-low reset
//   dut_run / dut_busy            start request / run in progress
//   input_sram_*                  image reads (write side tied 0)
//   weights_sram_*                kernel reads (write side tied 0)
//   output_sram_*                 result writes (read side tied 0)
//   scratchpad_sram_*             unused, outputs tied 0
module my_design #(
  parameter int N     = 16,
  parameter int ACC_W = 20
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        dut_run,
  output logic        dut_busy,
  output logic        input_sram_write_enable,
  output logic [11:0] input_sram_write_addresss,
  output logic [15:0] input_sram_write_data,
  output logic [11:0] input_sram_read_address,
  input  logic [15:0] input_sram_read_data,
  output logic        output_sram_write_enable,
  output logic [11:0] output_sram_write_addresss,
  output logic [15:0] output_sram_write_data,
  output logic [11:0] output_sram_read_address,
  input  logic [15:0] output_sram_read_data,
  output logic        scratchpad_sram_write_enable,
  output logic [11:0] scratchpad_sram_write_addresss,
  output logic [15:0] scratchpad_sram_write_data,
  output logic [11:0] scratchpad_sram_read_address,
  input  logic [15:0] scratchpad_sram_read_data,
  output logic        weights_sram_write_enable,
  output logic [11:0] weights_sram_write_addresss,
  output logic [15:0] weights_sram_write_data,
  output logic [11:0] weights_sram_read_address,
  input  logic [15:0] weights_sram_read_data
);

`ifdef MULTI_INPUT_EN
  localparam int MAX_DIM = 64;
`else
  localparam int MAX_DIM = N;
`endif
  localparam int IMG_SZ = MAX_DIM * MAX_DIM;
  localparam int IDX_W  = $clog2(IMG_SZ);
  localparam int NW_W   = IDX_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SIZE  = 3'd1,
    S_LOAD  = 3'd2,
    S_COMP  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t state_r, state_nx_s;

  logic              busy_r;
  logic [11:0]       in_addr_r;
  logic [11:0]       w_addr_r;
  logic              we_r;
  logic [11:0]       waddr_r;
  logic [15:0]       wdata_r;

  // Read pipeline: issued word index travels two stages to meet its data.
  logic [NW_W-1:0]   iss_cnt_r;
  logic              v1_r, v2_r;
  logic [NW_W-1:0]   idx1_r, idx2_r;

  logic signed [7:0] kern_r [0:9];
  logic signed [7:0] img_r  [0:IMG_SZ-1];

  // Output scan position; pix_base_r is the image index of the window's top-left.
  logic [5:0]        r_r, c_r;
  logic [IDX_W-1:0]  pix_base_r;
  logic              half_r;
  logic [7:0]        hi_r;
  logic              done_r;

  logic [6:0]        dim_s;
  logic [NW_W-1:0]   n_words_s;
  logic [11:0]       base_s;
  logic              kern_en_s;

`ifdef MULTI_INPUT_EN
  logic [6:0]        dim_r;
  logic [NW_W-1:0]   n_words_r;
  logic [11:0]       base_r;
  logic [11:0]       ptr_r;
  logic              kern_load_r;
  logic              sz_cnt_r;
  logic [6:0]        sz_dim_s;
  logic [13:0]       sz_sq_s;
  logic [NW_W-1:0]   sz_words_s;
  logic              sz_end_s;

  assign dim_s      = dim_r;
  assign n_words_s  = n_words_r;
  assign base_s     = base_r;
  assign kern_en_s  = kern_load_r;
  assign sz_dim_s   = input_sram_read_data[6:0];
  assign sz_sq_s    = 14'(sz_dim_s) * 14'(sz_dim_s);
  assign sz_words_s = NW_W'(sz_sq_s >> 1);
  assign sz_end_s   = (input_sram_read_data == 16'hFFFF);
`else
  assign dim_s      = 7'(N);
  assign n_words_s  = NW_W'(N * N / 2);
  assign base_s     = 12'd0;
  assign kern_en_s  = 1'b1;
`endif

  logic [6:0]        odim_s;
  logic              last_col_s, last_row_s, last_pix_s;
  logic              load_done_s;
  logic              word_ready_s;
  logic [IDX_W-1:0]  row_off_s [0:2];
  logic signed [ACC_W-1:0] sum_s;
  logic [7:0]        pix_s;

  assign odim_s       = dim_s - 7'd2;
  assign last_col_s   = ({1'b0, c_r} == (odim_s - 7'd1));
  assign last_row_s   = ({1'b0, r_r} == (odim_s - 7'd1));
  assign last_pix_s   = last_col_s && last_row_s;
  assign load_done_s  = v2_r && (idx2_r == (n_words_s - NW_W'(1)));
  assign word_ready_s = half_r || last_pix_s;
  assign row_off_s[0] = IDX_W'(0);
  assign row_off_s[1] = IDX_W'(dim_s);
  assign row_off_s[2] = IDX_W'({dim_s, 1'b0});

  // Negative sums clamp to 0, sums above 127 clamp to 127.
  function automatic logic [7:0] relu_sat(input logic signed [ACC_W-1:0] s);
    if (s < $signed(ACC_W'(0))) begin
      relu_sat = 8'h00;
    end else if (s > $signed(ACC_W'(127))) begin
      relu_sat = 8'h7F;
    end else begin
      relu_sat = s[7:0];
    end
  endfunction

  // 3x3 window multiply-accumulate for the current output pixel.
  always_comb begin : win_sum
    logic signed [15:0] prod;
    logic [IDX_W-1:0]   idx;
    sum_s = '0;
    prod  = '0;
    idx   = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        idx   = pix_base_r + row_off_s[i] + IDX_W'(j);
        prod  = kern_r[4'(i * 3 + j)] * img_r[idx];
        sum_s = sum_s + ACC_W'(prod);
      end
    end
  end

  assign pix_s = relu_sat(sum_s);

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (dut_run) begin
`ifdef MULTI_INPUT_EN
          state_nx_s = S_SIZE;
`else
          state_nx_s = S_LOAD;
`endif
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_SIZE: begin
`ifdef MULTI_INPUT_EN
        if (sz_cnt_r) begin
          if (sz_end_s) begin
            state_nx_s = S_IDLE;
          end else begin
            state_nx_s = S_LOAD;
          end
        end else begin
          state_nx_s = S_SIZE;
        end
`else
        state_nx_s = S_IDLE;
`endif
      end
      S_LOAD: begin
        if (load_done_s) begin
          state_nx_s = S_COMP;
        end else begin
          state_nx_s = S_LOAD;
        end
      end
      S_COMP: begin
        if (word_ready_s) begin
          state_nx_s = S_WRITE;
        end else begin
          state_nx_s = S_COMP;
        end
      end
      S_WRITE: begin
        if (done_r) begin
`ifdef MULTI_INPUT_EN
          state_nx_s = S_SIZE;
`else
          state_nx_s = S_IDLE;
`endif
        end else begin
          state_nx_s = S_COMP;
        end
      end
      default: state_nx_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Control/datapath registers: read issue, scan counters and write port.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      busy_r     <= 1'b0;
      in_addr_r  <= 12'd0;
      w_addr_r   <= 12'd0;
      we_r       <= 1'b0;
      waddr_r    <= 12'd0;
      wdata_r    <= 16'd0;
      iss_cnt_r  <= '0;
      v1_r       <= 1'b0;
      v2_r       <= 1'b0;
      idx1_r     <= '0;
      idx2_r     <= '0;
      r_r        <= 6'd0;
      c_r        <= 6'd0;
      pix_base_r <= '0;
      half_r     <= 1'b0;
      hi_r       <= 8'd0;
      done_r     <= 1'b0;
`ifdef MULTI_INPUT_EN
      dim_r       <= 7'd0;
      n_words_r   <= '0;
      base_r      <= 12'd0;
      ptr_r       <= 12'd0;
      kern_load_r <= 1'b0;
      sz_cnt_r    <= 1'b0;
`endif
    end else begin
      busy_r <= (state_nx_s != S_IDLE);
      we_r   <= 1'b0;
      v1_r   <= 1'b0;
      v2_r   <= v1_r;
      idx2_r <= idx1_r;
      case (state_r)
        S_IDLE: begin
          if (dut_run) begin
            waddr_r   <= 12'd0;
            iss_cnt_r <= '0;
            in_addr_r <= 12'd0;
`ifdef MULTI_INPUT_EN
            ptr_r       <= 12'd0;
            kern_load_r <= 1'b1;
            sz_cnt_r    <= 1'b0;
`endif
          end
        end
        S_SIZE: begin
`ifdef MULTI_INPUT_EN
          sz_cnt_r <= ~sz_cnt_r;
          if (sz_cnt_r) begin
            dim_r     <= sz_dim_s;
            n_words_r <= sz_words_s;
            base_r    <= ptr_r + 12'd1;
            ptr_r     <= ptr_r + 12'd1 + 12'(sz_words_s);
            iss_cnt_r <= '0;
          end
`endif
        end
        S_LOAD: begin
          if (iss_cnt_r < n_words_s) begin
            in_addr_r <= base_s + 12'(iss_cnt_r);
            w_addr_r  <= (iss_cnt_r < NW_W'(5)) ? 12'(iss_cnt_r) : 12'd0;
            v1_r      <= 1'b1;
            idx1_r    <= iss_cnt_r;
            iss_cnt_r <= iss_cnt_r + NW_W'(1);
          end
          if (load_done_s) begin
            r_r        <= 6'd0;
            c_r        <= 6'd0;
            pix_base_r <= '0;
            half_r     <= 1'b0;
            done_r     <= 1'b0;
`ifdef MULTI_INPUT_EN
            kern_load_r <= 1'b0;
`endif
          end
        end
        S_COMP: begin
          // Even pixels wait in hi_r; a word leaves on every odd pixel or at the end.
          if (half_r) begin
            wdata_r <= {hi_r, pix_s};
            we_r    <= 1'b1;
            half_r  <= 1'b0;
          end else if (last_pix_s) begin
            wdata_r <= {pix_s, 8'h00};
            we_r    <= 1'b1;
          end else begin
            hi_r   <= pix_s;
            half_r <= 1'b1;
          end
          if (last_pix_s) begin
            done_r <= 1'b1;
          end else if (last_col_s) begin
            c_r        <= 6'd0;
            r_r        <= r_r + 6'd1;
            pix_base_r <= pix_base_r + IDX_W'(3);
          end else begin
            c_r        <= c_r + 6'd1;
            pix_base_r <= pix_base_r + IDX_W'(1);
          end
        end
        S_WRITE: begin
          waddr_r <= waddr_r + 12'd1;
`ifdef MULTI_INPUT_EN
          if (done_r) begin
            in_addr_r <= ptr_r;
            sz_cnt_r  <= 1'b0;
          end
`endif
        end
        default: begin
          we_r <= 1'b0;
        end
      endcase
    end
  end

  // Image and kernel storage; always fully reloaded before use, so no reset.
  always_ff @(posedge clk) begin
    if (v2_r && (state_r == S_LOAD)) begin
      img_r[IDX_W'({idx2_r, 1'b0})] <= input_sram_read_data[15:8];
      img_r[IDX_W'({idx2_r, 1'b1})] <= input_sram_read_data[7:0];
      if (kern_en_s && (idx2_r < NW_W'(5))) begin
        kern_r[{idx2_r[2:0], 1'b0}] <= weights_sram_read_data[15:8];
        kern_r[{idx2_r[2:0], 1'b1}] <= weights_sram_read_data[7:0];
      end
    end
  end

  logic unused_rd_s;
  assign unused_rd_s = ^{output_sram_read_data, scratchpad_sram_read_data};

  assign dut_busy                       = busy_r;
  assign input_sram_write_enable        = 1'b0;
  assign input_sram_write_addresss      = 12'd0;
  assign input_sram_write_data          = 16'd0;
  assign input_sram_read_address        = in_addr_r;
  assign output_sram_write_enable       = we_r;
  assign output_sram_write_addresss     = waddr_r;
  assign output_sram_write_data         = wdata_r;
  assign output_sram_read_address       = 12'd0;
  assign scratchpad_sram_write_enable   = 1'b0;
  assign scratchpad_sram_write_addresss = 12'd0;
  assign scratchpad_sram_write_data     = 16'd0;
  assign scratchpad_sram_read_address   = 12'd0;
  assign weights_sram_write_enable      = 1'b0;
  assign weights_sram_write_addresss    = 12'd0;
  assign weights_sram_write_data        = 16'd0;
  assign weights_sram_read_address      = w_addr_r;

endmodule

// File: tb/tb_my_design.sv
// Self-checking bench for my_design (default build, N=16).
// SRAM models with one-cycle read latency surround the DUT; a behavioural
// convolution model builds the expected output words, and one compare
// process checks every output write against them in order.
module tb_my_design;
  localparam int N  = 16;
  localparam int ON = N - 2;

  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic        dut_run = 1'b0;
  logic        dut_busy;
  logic        in_we, out_we, sp_we, w_we;
  logic [11:0] in_wa, in_ra, out_wa, out_ra, sp_wa, sp_ra, w_wa, w_ra;
  logic [15:0] in_wd, out_wd, sp_wd, w_wd;
  logic [15:0] in_rd, w_rd;
  logic [15:0] out_rd = 16'hA5A5;
  logic [15:0] sp_rd  = 16'h5A5A;

  logic [15:0] in_mem [0:4095];
  logic [15:0] w_mem  [0:15];

  int ker [0:8];
  int img [0:N*N-1];

  logic [15:0] exp_q [$];
  logic [11:0] exp_addr;
  int          writes_in_run;
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  my_design dut (
    .clk(clk), .reset_b(reset_b), .dut_run(dut_run), .dut_busy(dut_busy),
    .input_sram_write_enable(in_we), .input_sram_write_addresss(in_wa),
    .input_sram_write_data(in_wd), .input_sram_read_address(in_ra),
    .input_sram_read_data(in_rd),
    .output_sram_write_enable(out_we), .output_sram_write_addresss(out_wa),
    .output_sram_write_data(out_wd), .output_sram_read_address(out_ra),
    .output_sram_read_data(out_rd),
    .scratchpad_sram_write_enable(sp_we), .scratchpad_sram_write_addresss(sp_wa),
    .scratchpad_sram_write_data(sp_wd), .scratchpad_sram_read_address(sp_ra),
    .scratchpad_sram_read_data(sp_rd),
    .weights_sram_write_enable(w_we), .weights_sram_write_addresss(w_wa),
    .weights_sram_write_data(w_wd), .weights_sram_read_address(w_ra),
    .weights_sram_read_data(w_rd)
  );

  // Synchronous SRAM read ports: data appears one clock after the address.
  always @(posedge clk) begin
    in_rd <= in_mem[in_ra];
    w_rd  <= w_mem[w_ra[3:0]];
  end

  // Compare process: every output write must be the next expected word.
  always @(negedge clk) begin
    logic [15:0] ew;
    if (reset_b && out_we) begin
      writes_in_run++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: addr %0d data %h, no write expected", out_wa, out_wd);
      end else begin
        ew = exp_q.pop_front();
        if (out_wa !== exp_addr || out_wd !== ew) begin
          n_fail++;
          $display("FAIL out_word: got addr %0d data %h, expected addr %0d data %h",
                   out_wa, out_wd, exp_addr, ew);
        end
        exp_addr = exp_addr + 12'd1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pack kernel/image into the SRAMs, high byte = even element.
  task automatic load_mems();
    for (int w = 0; w < N * N / 2; w++) begin
      in_mem[w] = {8'(img[2*w]), 8'(img[2*w+1])};
    end
    for (int w = 0; w < 4; w++) begin
      w_mem[w] = {8'(ker[2*w]), 8'(ker[2*w+1])};
    end
    w_mem[4] = {8'(ker[8]), 8'($urandom_range(0, 255))};
  endtask

  // Behavioural model: plain convolution, clamp, pack into expected words.
  task automatic build_expected();
    int ob [0:ON*ON-1];
    int s;
    exp_q.delete();
    exp_addr = 12'd0;
    writes_in_run = 0;
    for (int r = 0; r < ON; r++) begin
      for (int c = 0; c < ON; c++) begin
        s = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            s += ker[i*3+j] * img[(r+i)*N + c + j];
        ob[r*ON+c] = (s < 0) ? 0 : ((s > 127) ? 127 : s);
      end
    end
    for (int k = 0; k < ON * ON; k += 2) begin
      exp_q.push_back({8'(ob[k]), (k + 1 < ON * ON) ? 8'(ob[k+1]) : 8'h00});
    end
    load_mems();
  endtask

  task automatic do_run(input bit mid_pulse);
    int  cyc;
    bit  rose;
    @(negedge clk);
    check("idle_before_run", {31'd0, dut_busy}, 32'd0);
    dut_run = 1'b1;
    @(negedge clk);
    dut_run = 1'b0;
    rose = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (dut_busy) rose = 1'b1;
      if (!rose) @(negedge clk);
    end
    check("busy_rise", {31'd0, rose}, 32'd1);
    cyc = 1;
    while (dut_busy && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      dut_run = (mid_pulse && cyc == 60);
    end
    dut_run = 1'b0;
    check("run_latency_busy_fall", {31'd0, dut_busy}, 32'd0);
    check("all_words_written", exp_q.size(), 32'd0);
    check("write_count", writes_in_run, (ON * ON + 1) / 2);
  endtask

  task automatic rand_img();
    for (int i = 0; i < N * N; i++) img[i] = int'($urandom_range(0, 255)) - 128;
  endtask

  initial begin
    int kmix [0:8] = '{1, -2, 3, -4, 5, -6, 7, -8, 9};
    int cnt;
    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, dut_busy}, 32'd0);
    check("rst_we", {31'd0, out_we}, 32'd0);
    check("rst_waddr", out_wa, 32'd0);
    check("rst_wdata", out_wd, 32'd0);
    check("rst_in_raddr", in_ra, 32'd0);
    check("rst_w_raddr", w_ra, 32'd0);
    check("tied_outputs", {in_we, in_wa, in_wd, out_ra, sp_we, sp_wa, sp_wd, sp_ra, w_we, w_wa, w_wd}, 32'd0);
    reset_b = 1'b1;

    // T1: identity kernel -> out(r,c) = in(r+1,c+1).
    for (int i = 0; i < 9; i++) ker[i] = (i == 4) ? 1 : 0;
    for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) img[r*N+c] = (r * 16 + c) % 100;
    build_expected();
    check("model_word_count", exp_q.size(), 32'd98);
    check("model_t1_first", exp_q[0], 32'h1112);
    check("model_t1_last", exp_q[97], 32'h2526);
    do_run(1'b0);

    // T2: all-ones kernel on 20s saturates high.
    for (int i = 0; i < 9; i++) ker[i] = 1;
    for (int i = 0; i < N * N; i++) img[i] = 20;
    build_expected();
    check("model_t2_sat", exp_q[50], 32'h7F7F);
    do_run(1'b0);

    // T3: all-ones kernel on -10s clamps to zero.
    for (int i = 0; i < N * N; i++) img[i] = -10;
    build_expected();
    check("model_t3_zero", exp_q[10], 32'h0000);
    do_run(1'b0);

    // T4: mixed kernel, random image, stray dut_run mid-run.
    for (int i = 0; i < 9; i++) ker[i] = kmix[i];
    rand_img();
    build_expected();
    do_run(1'b1);

    // T5: reset during a write, then a clean run.
    rand_img();
    build_expected();
    @(negedge clk);
    dut_run = 1'b1;
    @(negedge clk);
    dut_run = 1'b0;
    cnt = 0;
    while (!(out_we && writes_in_run >= 30) && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    check("reached_write", {31'd0, out_we}, 32'd1);
    #2 reset_b = 1'b0;
    #1;
    check("abort_busy", {31'd0, dut_busy}, 32'd0);
    check("abort_we", {31'd0, out_we}, 32'd0);
    check("abort_waddr", out_wa, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_b = 1'b1;
    repeat (20) @(negedge clk);
    check("no_write_after_abort", {31'd0, out_we}, 32'd0);
    build_expected();
    do_run(1'b0);

    // T6: back-to-back runs with different data.
    for (int i = 0; i < 9; i++) ker[i] = int'($urandom_range(0, 255)) - 128;
    rand_img();
    build_expected();
    do_run(1'b0);
    for (int i = 0; i < 9; i++) ker[i] = int'($urandom_range(0, 6)) - 3;
    rand_img();
    build_expected();
    do_run(1'b0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
